// File: rtl/spi_reg_slave_if.sv
// SPI pin bundle between a mode-0 master and the register-file responder.
interface spi_reg_slave_if;
    logic SCLK;
    logic MOSI;
    logic SS_n;
    logic MISO;

    modport master (
        output SCLK,
        output MOSI,
        output SS_n,
        input  MISO
    );

    modport slave (
        input  SCLK,
        input  MOSI,
        input  SS_n,
        output MISO
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register-file responder, oversampled in the clk domain.
// Define SPI_REG_SLAVE_MISO_HIZ_EN to tri-state MISO while deselected.
module spi_reg_slave #(
    parameter int          NUM_REGS    = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  STATUS_BYTE = 8'hA5,
    localparam int         AW          = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_reg_slave_if.slave        spi,
    input  logic                  host_we,
    input  logic [AW-1:0]         host_addr,
    input  logic [7:0]            host_wdata,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic [7:0]            rx_byte,
    output logic                  rx_done,
    output logic                  wr_strobe,
    output logic [AW-1:0]         wr_addr,
    output logic                  frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_d, ss_d;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic active, byte_done;

    logic [7:0]    regs [NUM_REGS];
    logic [6:0]    rx_shift;
    logic [7:0]    rx_next;
    logic [7:0]    tx_shift;
    logic [2:0]    bit_cnt;
    logic          load_pend;
    logic          cmd_wr;
    logic [AW-1:0] addr;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // SS_n chain resets low so a select held across reset is not seen as a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi.SCLK};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi.SS_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi.MOSI};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
        end
    end

    assign sclk_rise = sclk_s & ~sclk_d & ~ss_s;
    assign sclk_fall = ~sclk_s & sclk_d & ~ss_s;
    assign ss_fall   = ss_d & ~ss_s;
    assign ss_rise   = ~ss_d & ss_s;
    assign active    = (state_q != IDLE);
    assign rx_next   = {rx_shift, mosi_s};
    assign byte_done = active & sclk_rise & (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ss_fall) state_d = CMD;
            CMD:     if (byte_done) state_d = DATA;
            DATA:    state_d = DATA;
            default: state_d = IDLE;
        endcase
        if (ss_rise) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
            rx_shift  <= '0;
            rx_byte   <= 8'h00;
            tx_shift  <= 8'h00;
            bit_cnt   <= 3'd0;
            load_pend <= 1'b0;
            cmd_wr    <= 1'b0;
            addr      <= '0;
            wr_addr   <= '0;
            rx_done   <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            if (host_we) regs[host_addr] <= host_wdata;
            if (ss_rise) begin
                bit_cnt   <= 3'd0;
                load_pend <= 1'b0;
                frame_err <= (bit_cnt != 3'd0);
            end else if (!active) begin
                if (ss_fall) begin
                    tx_shift <= STATUS_BYTE;
                    bit_cnt  <= 3'd0;
                end
            end else begin
                if (sclk_rise) begin
                    rx_shift <= rx_next[6:0];
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_byte   <= rx_next;
                        rx_done   <= 1'b1;
                        load_pend <= 1'b1;
                        if (state_q == CMD) begin
                            cmd_wr <= rx_next[7];
                            addr   <= rx_next[AW-1:0];
                        end else begin
                            // Placed after the host write so the SPI write wins a tie.
                            if (cmd_wr) begin
                                regs[addr] <= rx_next;
                                wr_strobe  <= 1'b1;
                                wr_addr    <= addr;
                            end
                            addr <= addr + 1'b1;
                        end
                    end
                end
                if (sclk_fall) begin
                    load_pend <= 1'b0;
                    if (load_pend) begin
                        tx_shift <= cmd_wr ? 8'h00 : regs[addr];
                    end else begin
                        tx_shift <= {tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs[i];
    end

`ifdef SPI_REG_SLAVE_MISO_HIZ_EN
    assign spi.MISO = (ss_s || rst) ? 1'bz : tx_shift[7];
`else
    assign spi.MISO = ss_s ? 1'b0 : tx_shift[7];
`endif

endmodule

// File: tb/tb_spi_reg_slave.sv
// Randomized scoreboard bench for spi_reg_slave: SPI master driver,
// register-file reference model and decoupled output monitors.
module tb_spi_reg_slave;

    localparam int N    = 4;
    localparam int AW   = 2;
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_reg_slave_if bus ();

    logic            host_we;
    logic [AW-1:0]   host_addr;
    logic [7:0]      host_wdata;
    logic [8*N-1:0]  regs_flat;
    logic [7:0]      rx_byte;
    logic            rx_done;
    logic            wr_strobe;
    logic [AW-1:0]   wr_addr;
    logic            frame_err;

    spi_reg_slave #(
        .NUM_REGS    (N),
        .SYNC_STAGES (2),
        .STATUS_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (bus.slave),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .regs_flat  (regs_flat),
        .rx_byte    (rx_byte),
        .rx_done    (rx_done),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .frame_err  (frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  model [N];
    logic [7:0]  exp_rx [$];
    logic [7:0]  exp_miso [$];
    logic [15:0] exp_wr [$];
    int          exp_ferr = 0;
    int          got_ferr = 0;
    int          mcnt = 0;
    logic [7:0]  msh = 8'h00;
    logic [7:0]  fr [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got an output with nothing expected", name);
    endtask

    function automatic logic [8*N-1:0] model_flat();
        logic [8*N-1:0] f;
        for (int i = 0; i < N; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    // rx_done / wr_strobe / frame_err monitor
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (rx_done) begin
                if (exp_rx.size() == 0) unexpected("rx_done");
                else chk("rx_byte", 64'(rx_byte), 64'(exp_rx.pop_front()));
            end
            if (wr_strobe) begin
                if (exp_wr.size() == 0) unexpected("wr_strobe");
                else begin
                    e = exp_wr.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(e[15:8]));
                    chk("wr_data", 64'(regs_flat[8*int'(e[15:8]) +: 8]), 64'(e[7:0]));
                end
            end
            if (frame_err) got_ferr++;
        end
    end

    // MISO monitor: samples like the master on SCLK rise, drops partial bytes
    initial begin
        forever begin
            @(posedge bus.SCLK or posedge bus.SS_n);
            if (bus.SS_n === 1'b1) begin
                mcnt = 0;
            end else begin
                msh = {msh[6:0], bus.MISO};
                mcnt++;
                if (mcnt == 8) begin
                    mcnt = 0;
                    if (exp_miso.size() == 0) unexpected("miso");
                    else chk("miso_byte", 64'(msh), 64'(exp_miso.pop_front()));
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk);
        host_we    = 1'b1;
        host_addr  = a;
        host_wdata = d;
        @(negedge clk);
        host_we = 1'b0;
        model[a] = d;
    endtask

    // abort_bits>0 truncates the last byte; coll fires host_we in the clk of the last byte's action
    task automatic send_frame(input logic [7:0] b[$], input int abort_bits,
                              input bit coll, input logic [AW-1:0] caddr,
                              input logic [7:0] cdata);
        int            n = b.size();
        bit            wr = 1'b0;
        logic [AW-1:0] a = '0;
        int            nb;
        for (int k = 0; k < n; k++) begin
            if (k == n - 1 && abort_bits > 0) begin
                exp_ferr++;
                break;
            end
            if (k == 0) begin
                exp_miso.push_back(8'hA5);
                wr = b[0][7];
                a  = b[0][AW-1:0];
            end else begin
                exp_miso.push_back(wr ? 8'h00 : model[a]);
            end
            exp_rx.push_back(b[k]);
            if (k == n - 1 && coll) model[caddr] = cdata;
            if (k > 0) begin
                if (wr) begin
                    model[a] = b[k];
                    exp_wr.push_back({6'b0, a, b[k]});
                end
                a = a + 1'b1;
            end
        end
        bus.SS_n = 1'b0;
        wait_clk(HALF);
        for (int k = 0; k < n; k++) begin
            nb = (k == n - 1 && abort_bits > 0) ? abort_bits : 8;
            for (int i = 0; i < nb; i++) begin
                bus.MOSI = b[k][7-i];
                wait_clk(HALF);
                bus.SCLK = 1'b1;
                for (int j = 1; j <= HALF; j++) begin
                    @(negedge clk);
                    if (coll && abort_bits == 0 && k == n - 1 && i == 7) begin
                        if (j == 2) begin
                            host_we    = 1'b1;
                            host_addr  = caddr;
                            host_wdata = cdata;
                        end
                        if (j == 3) host_we = 1'b0;
                    end
                end
                bus.SCLK = 1'b0;
            end
        end
        wait_clk(HALF);
        bus.SS_n = 1'b1;
        wait_clk(3 * HALF);
        chk("regs_after_frame", 64'(regs_flat), 64'(model_flat()));
    endtask

    initial begin
        int            n;
        int            ab;
        bit            cl;
        logic [AW-1:0] ca;
        logic [7:0]    cd;

        rst        = 1'b1;
        bus.SS_n   = 1'b1;
        bus.SCLK   = 1'b0;
        bus.MOSI   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = 8'h00;
        for (int i = 0; i < N; i++) model[i] = 8'h00;
        wait_clk(4);
        rst = 1'b0;
        chk("reset_regs", 64'(regs_flat), 64'(model_flat()));
        chk("reset_rx_byte", 64'(rx_byte), 64'h0);
        chk("reset_wr_addr", 64'(wr_addr), 64'h0);
        chk("reset_pulses", 64'({rx_done, wr_strobe, frame_err}), 64'h0);
        chk("reset_miso", 64'(bus.MISO), 64'h0);
        wait_clk(8);

        fr = {8'h00};
        send_frame(fr, 0, 1'b0, '0, 8'h00);
        fr = {8'h82, 8'h3C};
        send_frame(fr, 0, 1'b0, '0, 8'h00);
        host_write(2'd1, 8'h5A);
        fr = {8'h01, 8'hFF};
        send_frame(fr, 0, 1'b0, '0, 8'h00);
        fr = {8'h83, 8'h11, 8'h22, 8'h33};
        send_frame(fr, 0, 1'b0, '0, 8'h00);
        fr = {8'h80, 8'hC7};
        send_frame(fr, 5, 1'b0, '0, 8'h00);
        fr = {8'h82, 8'h77};
        send_frame(fr, 0, 1'b1, 2'd2, 8'hEE);
        chk("collision_reg2", 64'(regs_flat[23:16]), 64'h77);
        fr = {8'h81, 8'h42};
        send_frame(fr, 0, 1'b1, 2'd3, 8'h9C);
        chk("collision_reg3", 64'(regs_flat[31:24]), 64'h9C);

`ifdef SPI_REG_SLAVE_MISO_HIZ_EN
        chk("miso_deselected", 64'(bus.MISO), 64'(1'bz));
`else
        chk("miso_deselected", 64'(bus.MISO), 64'h0);
`endif

        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0) host_write(AW'($urandom_range(0, N - 1)), 8'($urandom));
            n = $urandom_range(1, 5);
            fr = {};
            for (int k = 0; k < n; k++) fr.push_back(8'($urandom));
            ab = (n >= 2 && $urandom_range(0, 4) == 0) ? $urandom_range(1, 7) : 0;
            cl = (ab == 0 && $urandom_range(0, 3) == 0);
            ca = AW'($urandom_range(0, N - 1));
            cd = 8'($urandom);
            send_frame(fr, ab, cl, ca, cd);
        end

        wait_clk(10);
        chk("frame_err_count", 64'(got_ferr), 64'(exp_ferr));
        chk("rx_pending", 64'(exp_rx.size()), 64'h0);
        chk("wr_pending", 64'(exp_wr.size()), 64'h0);
        chk("miso_pending", 64'(exp_miso.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) for the system-clock-domain SPI master.
- Oversamples SCLK, SS_n and MOSI in the clk domain, decodes a command/data byte protocol, and exposes a small register file.
- The master reads and writes the register file over SPI; local logic reads it through a flat bus and can also write it.

Parameters:
- NUM_REGS, 4, number of 8-bit registers; power of 2, minimum 2; AW = clog2(NUM_REGS).
- SYNC_STAGES, 2, flip-flop depth of the input synchronizers for SCLK, SS_n and MOSI.
- STATUS_BYTE, 8'hA5, byte shifted out on MISO during every command byte.

Ports:
- clk, input, 1, system clock; must run at least 8x the SCLK frequency.
- rst, input, 1, synchronous, active-high reset.
- SCLK, input, 1, SPI clock from the master (asynchronous to clk).
- MOSI, input, 1, master-out data.
- SS_n, input, 1, active-low slave select.
- MISO, output, 1, slave-out data.
- host_we, input, 1, local register write enable.
- host_addr, input, AW, local write address.
- host_wdata, input, 8, local write data.
- regs_flat, output, 8*NUM_REGS, register contents; reg i sits at [8i+7:8i].
- rx_byte, output, 8, last complete byte received on MOSI.
- rx_done, output, 1, one-clk pulse per complete received byte.
- wr_strobe, output, 1, one-clk pulse when an SPI write updates a register.
- wr_addr, output, AW, register address of the last SPI write.
- frame_err, output, 1, one-clk pulse when SS_n deasserts mid-byte.

Behaviour:
- Reset: all registers, rx_byte, wr_addr = 0; rx_done, wr_strobe, frame_err = 0; MISO = 0; FSM in IDLE; bit counter = 0.
- Synchronization: SCLK, SS_n and MOSI each pass through SYNC_STAGES flip-flops.
  - Edges are detected on the synchronized SCLK against a one-cycle-delayed copy.
  - Edges are ignored while the synchronized SS_n is high.
- Rising edge: shift MOSI into rx_shift (MSB first) and increment the 3-bit counter.
  - On the 8th rise: rx_byte <= assembled byte, rx_done pulses on the next clk, counter wraps to 0.
- Falling edge: shift tx_shift left; MISO = tx_shift[7].
  - Exception: on the falling edge directly after a completed byte, tx_shift is loaded instead of shifted.
- FSM states:
  - IDLE: on synchronized SS_n falling, load tx_shift <= STATUS_BYTE and go to CMD.
  - CMD: at byte complete, latch cmd_wr = bit7 and addr = bits[AW-1:0]; bits[6:AW] are ignored. Go to DATA.
    - On the following falling edge, tx_shift loads regs[addr] if cmd_wr=0, else 8'h00.
  - DATA, write: at byte complete, regs[addr] <= rx_byte; wr_strobe pulses together with rx_done; wr_addr <= addr.
  - DATA, read: the byte shifted out is regs[addr], sampled at load time.
  - DATA, either direction: after each complete byte, addr <= addr+1 modulo NUM_REGS, so NUM_REGS-1 wraps to 0.
    - The next tx load uses the new addr (burst read/write).
  - Any state: synchronized SS_n rising returns to IDLE and clears the counter. If the counter was nonzero, frame_err pulses and the partial byte is discarded (no write, no rx_done).
- Simultaneous SPI write and host_we to the same register in the same clk: the SPI write wins. Different addresses: both writes take effect.
- rst mid-frame: immediate return to reset state; the frame resumes only after SS_n goes high and then low again.
- Latency: SCLK pin edge to internal action is SYNC_STAGES+1 clk.

Optional Feature:
- Macro: SPI_REG_SLAVE_MISO_HIZ_EN.
- Defined: MISO = 1'bz whenever synchronized SS_n is high or rst is asserted; enables multi-slave buses.
- Undefined: MISO is driven 0 while deselected.

Test Plan:
- Reset, then SS_n low and 8 SCLK with MOSI=8'h00 -> MISO bits read 8'hA5; rx_done pulses once; rx_byte=8'h00.
- Frame 8'h82,8'h3C -> regs[2]=8'h3C; wr_strobe pulses once with wr_addr=2; regs_flat[23:16]=8'h3C.
- host write regs[1]=8'h5A, then frame 8'h01,8'hFF -> MISO second byte = 8'h5A; regs unchanged.
- Burst 8'h83,8'h11,8'h22,8'h33 -> regs[3]=11, regs[0]=22 (wrap), regs[1]=33; three wr_strobe pulses.
- SS_n high after 5 bits of the data byte in an 8'h80 frame -> frame_err pulses, regs[0] unchanged, no rx_done for the partial byte.
- host_we to addr 2 in the same clk as the SPI write to regs[2]=8'h77 -> regs[2]=8'h77. With the macro defined and SS_n high -> MISO is z.
